// File: rtl/vector_alu_arbiter_pkg.sv
// Shared definitions for the vector ALU arbiter: opcode values,
// FSM state encoding and SIMD lane geometry.
package vector_alu_arbiter_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int DATA_W    = LANE_W * NUM_LANES;
    localparam int OPC_W     = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h3;
    localparam logic [OPC_W-1:0] OP_SHL = 4'h4;
    localparam logic [OPC_W-1:0] OP_SHR = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/vector_alu_arbiter_alu.sv
// vector_alu: combinational four-lane 8-bit SIMD datapath.
// Ports: opcode_i, op_a_i, op_b_i in; result_o, err_o (illegal opcode) out.
module vector_alu
    import vector_alu_arbiter_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              err_o
);

    // Each lane is computed in isolation, so carries and borrows
    // never cross lane boundaries.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [LANE_W-1:0] a;
        logic [LANE_W-1:0] b;
        logic [LANE_W-1:0] r;
        logic              big_shift;

        assign a = op_a_i[l*LANE_W +: LANE_W];
        assign b = op_b_i[l*LANE_W +: LANE_W];
        // Shifts of a full lane width or more clear the lane.
        assign big_shift = (b >= 8'(LANE_W));

        always_comb begin
            r = '0;
            case (opcode_i)
                OP_ADD:  r = a + b;
                OP_SUB:  r = a - b;
                OP_XOR:  r = a ^ b;
                OP_SHL:  r = big_shift ? '0 : (a << b[2:0]);
                OP_SHR:  r = big_shift ? '0 : (a >> b[2:0]);
                default: r = '0;
            endcase
        end

        assign result_o[l*LANE_W +: LANE_W] = r;
    end

    assign err_o = (opcode_i > OP_SHR);

endmodule

// File: rtl/vector_alu_arbiter.sv
// Round-robin arbiter sharing one vector_alu between NUM_REQ requesters.
// Ports: clk, rst_n, req_* (valid/ready/opcode/op_a/op_b), rsp_* (valid/ready/id/result/err).
module vector_alu_arbiter
    import vector_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OPC_W*NUM_REQ-1:0]  req_opcode,
    input  logic [DATA_W*NUM_REQ-1:0] req_op_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_op_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_err
);

    state_e              state_q;
    logic [ID_W-1:0]     last_grant_q;
    logic [ID_W-1:0]     id_q;
    logic [OPC_W-1:0]    opcode_q;
    logic [DATA_W-1:0]   op_a_q;
    logic [DATA_W-1:0]   op_b_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                rsp_err_q;

    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic [ID_W-1:0]     idx;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_err;

    // Search starts just after the last winner; the index wraps
    // naturally in ID_W bits, and i == NUM_REQ revisits last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = last_grant_q;
        idx         = last_grant_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last_grant_q + ID_W'(i);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == ST_IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    vector_alu u_alu (
        .opcode_i (opcode_q),
        .op_a_i   (op_a_q),
        .op_b_i   (op_b_q),
        .result_o (alu_result),
        .err_o    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            opcode_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // req_ready mirrors grant_found here, so this is
                    // exactly the valid/ready handshake edge.
                    if (grant_found) begin
                        opcode_q     <= req_opcode[OPC_W*grant_id +: OPC_W];
                        op_a_q       <= req_op_a[DATA_W*grant_id +: DATA_W];
                        op_b_q       <= req_op_b[DATA_W*grant_id +: DATA_W];
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_err_q    <= alu_err;
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_vector_alu_arbiter.sv
// Directed self-checking bench for vector_alu_arbiter.
// Drives on the falling edge, samples 1ns later, clock period 10ns.
module tb_vector_alu_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [15:0]  req_opcode;
    logic [127:0] req_op_a;
    logic [127:0] req_op_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic         rsp_err;

    int checks = 0;
    int errors = 0;

    vector_alu_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_op_a   (req_op_a),
        .req_op_b   (req_op_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input int id, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        req_opcode[id*4 +: 4] = op;
        req_op_a[id*32 +: 32] = a;
        req_op_b[id*32 +: 32] = b;
        req_valid[id]         = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_opcode = '0;
        req_op_a   = '0;
        req_op_b   = '0;
        rsp_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_err got %b%b want 00", rsp_valid, rsp_err);
        end
        checks++;
        if (rsp_result !== 32'h0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%0d want 0/0", rsp_result, rsp_id);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [31:0] exp_res;
        int exp;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            issue(i, 4'h1, 32'h01010101 * i, 32'h01010101);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp = k % 4;
            exp_rdy = 4'b0001 << exp;
            exp_res = 32'h01010101 * (exp + 1);
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant%0d got %b want %b", k, req_ready, exp_rdy);
            end
            @(negedge clk);
            #1;
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_exec%0d got %b/%b want 0000/0", k, req_ready, rsp_valid);
            end
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp) || rsp_result !== exp_res) begin
                errors++;
                $display("FAIL rr_resp%0d got %b/%0d/%h want 1/%0d/%h",
                         k, rsp_valid, rsp_id, rsp_result, exp, exp_res);
            end
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        issue(2, 4'h1, 32'h01020304, 32'h01010101);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL add_ready got %b want 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_early got %b want 0", rsp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h02030405 ||
            rsp_id !== 2'd2 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL add_resp got %b/%h/%0d/%b want 1/02030405/2/0",
                     rsp_valid, rsp_result, rsp_id, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_release got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_lane_wrap();
        @(negedge clk);
        issue(1, 4'h2, 32'h00FF7F80, 32'h01010101);
        issue(2, 4'h1, 32'h11111111, 32'h11111111);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_ready got %b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'hFFFE7E7F || rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL wrap_resp got %b/%h/%0d want 1/fffe7e7f/1",
                     rsp_valid, rsp_result, rsp_id);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_shift();
        @(negedge clk);
        issue(3, 4'h4, 32'h01010101, 32'h00070809);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL shl_ready got %b want 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_result !== 32'h01800000 || rsp_err !== 1'b0 || rsp_id !== 2'd3) begin
            errors++;
            $display("FAIL shl_resp got %h/%b/%0d want 01800000/0/3",
                     rsp_result, rsp_err, rsp_id);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        issue(0, 4'h5, 32'h80FF4010, 32'h07040908);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_result !== 32'h010F0000 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL shr_resp got %h/%0d want 010f0000/0", rsp_result, rsp_id);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_nop();
        @(negedge clk);
        issue(1, 4'h0, 32'hDEADBEEF, 32'h12345678);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL nop_resp got %b/%h/%b want 1/0/0", rsp_valid, rsp_result, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        issue(2, 4'h8, 32'hFFFFFFFF, 32'h01010101);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_ready got %b want 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        issue(3, 4'h1, 32'h0, 32'h0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_err !== 1'b1 ||
                rsp_id !== 2'd2 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d got %b/%h/%b/%0d/%b want 1/0/1/2/0000",
                         c, rsp_valid, rsp_result, rsp_err, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release got %b/%b want 0/1000", rsp_valid, req_ready);
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_single%0d got %b want 0", c, rsp_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        issue(3, 4'h1, 32'h01010101, 32'h01010101);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid_ready got %b want 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_hold got %b/%b want 0/0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_norsp%0d got %b want 0", c, rsp_valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            issue(i, 4'h3, 32'hF0F0F0F0, 32'hFF00FF00);
        end
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_first got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'h0FF00FF0) begin
            errors++;
            $display("FAIL rst_mid_resp got %b/%0d/%h want 1/0/0ff00ff0",
                     rsp_valid, rsp_id, rsp_result);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_add();
        test_lane_wrap();
        test_shift();
        test_nop();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_alu_arbiter.md
VECTOR_ALU_ARBITER -- requirements
Module: vector_alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requester ports; the only supported value is 4.
REQ-002 Parameter ID_W, default 2, meaning the width of the requester index, equal to log2(NUM_REQ).
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port req_valid, input, NUM_REQ, one per-requester operation-valid bit.
REQ-006 Port req_ready, output, NUM_REQ, one per-requester accept bit; at most one bit high in any cycle.
REQ-007 Port req_opcode, input, 4*NUM_REQ, packed opcodes; requester i occupies bits [4i+3:4i].
REQ-008 Port req_op_a, input, 32*NUM_REQ, packed operand A; requester i occupies bits [32i+31:32i].
REQ-009 Port req_op_b, input, 32*NUM_REQ, packed operand B, packed the same way as req_op_a.
REQ-010 Port rsp_valid, output, 1, response available.
REQ-011 Port rsp_ready, input, 1, consumer accepts the response.
REQ-012 Port rsp_id, output, ID_W, index of the requester that owns the response.
REQ-013 Port rsp_result, output, 32, four-lane SIMD result.
REQ-014 Port rsp_err, output, 1, set when the opcode was illegal.

Function
REQ-015 The block SHALL share one SIMD datapath (four 8-bit lanes, MSB lane first) between requesters, using a three-state FSM: IDLE, EXEC, RESP.
REQ-016 In IDLE with any req_valid set, the block SHALL select the requester by round-robin, starting the search at last_grant+1 mod NUM_REQ, and SHALL drive that requester's req_ready high combinationally in the same cycle.
REQ-017 In IDLE, on a rising edge where req_valid[g] and req_ready[g] are both high, the block SHALL latch opcode, op_a, op_b and g, update last_grant to g, and go to EXEC.
REQ-018 In IDLE with no req_valid set, the block SHALL stay in IDLE with all req_ready low.
REQ-019 In EXEC and RESP, all req_ready bits SHALL be low; requesters hold their requests.
REQ-020 EXEC SHALL last exactly one cycle: register the datapath output into rsp_result, register the error flag into rsp_err, load rsp_id, set rsp_valid, and go to RESP.
REQ-021 In RESP, the block SHALL hold rsp_valid, rsp_id, rsp_result and rsp_err stable until an edge where rsp_ready is high, then clear rsp_valid and return to IDLE.
REQ-022 A new grant SHALL NOT occur in the same cycle as a response handshake.
REQ-023 Latency SHALL be: accept at edge N, rsp_valid high after edge N+1; peak throughput is one operation per three cycles.
REQ-024 Opcodes, applied independently per lane with mod-256 wrap and no inter-lane carry: 0001 add; 0010 A-B; 0011 XOR; 0100 A<<B; 0101 A>>B.
REQ-025 Shifts SHALL be logical, and a shift amount of 8 or more SHALL yield 0 in that lane.
REQ-026 Opcode 0000 SHALL yield result 0 with rsp_err=0.
REQ-027 Opcodes 0110-1111 SHALL yield result 0 with rsp_err=1.
REQ-028 Requesters that drop req_valid before being granted SHALL NOT be served; no request is queued internally.

Reset
REQ-029 While rst_n is low, the FSM SHALL be in IDLE and outputs SHALL be: rsp_valid=0, rsp_err=0, rsp_result=0, rsp_id=0, req_ready=0.
REQ-030 While rst_n is low, last_grant SHALL be NUM_REQ-1 so that requester 0 has first priority.
REQ-031 Reset asserted in EXEC or RESP SHALL discard the in-flight operation without producing a response.
REQ-032 Grants SHALL resume on the first edge after rst_n deasserts.

Structure
REQ-033 A shared package SHALL hold the opcode constants (NOP, ADD, SUB, XOR, SHL, SHR), the FSM state encoding and the lane width of 8.
REQ-034 The lane arithmetic SHALL be one instantiated combinational sub-module, vector_alu, extended with the error flag; the arbiter itself holds all sequential logic.

Verification
REQ-035 Single add: requester 2 sends opcode 0001, A=0x01020304, B=0x01010101 -> req_ready[2] high in the same cycle; rsp_valid high two edges later with rsp_result=0x02030405, rsp_id=2, rsp_err=0.
REQ-036 Lane wrap: opcode 0010, A=0x00FF7F80, B=0x01010101 -> rsp_result=0xFFFE7E7F, no carry or borrow between lanes.
REQ-037 Round-robin fairness: all four requesters hold valid, rsp_ready tied high -> grant order 0,1,2,3,0.
REQ-038 Backpressure and illegal opcode: opcode 1000 with rsp_ready low for 5 cycles -> rsp_result=0 and rsp_err=1 held stable, req_ready all 0, then exactly one response on release.
REQ-039 Reset mid-operation: pull rst_n low during EXEC -> no response appears; after release, requester 0 is granted first.
REQ-040 Shift boundary: opcode 0100, A=0x01010101, B=0x00070809 -> rsp_result=0x01800000.
